pim_cmd_dispatch: RTL and testbench

Multi-channel command dispatcher for the PIM matrix-multiply memory. It accepts matmul commands (src1, src2, dst addresses) over a valid/ready interface and buffers them in an in-order FIFO. It issues each command as a one-cycle start pulse, with held addresses, to a free memory channel, round-robin. It replaces single-shot start driving and optionally blocks address hazards between in-flight operations.

---
 rtl/pim_cmd_dispatch.sv | 212 +++++++++++++++++++++
 tb/tb_pim_cmd_dispatch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_cmd_dispatch.sv
// pim_cmd_dispatch
// ----------------
// Multi-channel command dispatcher for the PIM matrix-multiply memory.
// Matmul commands (src1, src2, dst) are accepted over valid/ready into an
// in-order FIFO. The FIFO head is issued to the first free channel at or
// after a round-robin pointer, as a one-cycle start pulse with addresses
// that hold until the next dispatch to that channel.
//
// Optional feature macro: PIM_HAZARD_CHECK_EN
//   defined   - the head is held while any busy channel's dst address equals
//               the head's src1, src2 or dst (RAW/WAW protection)
//   undefined - dispatch depends only on FIFO and channel availability
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_src1/src2/dst        command addresses (LEN bits each)
//   ch_start                 per-channel one-cycle start pulse
//   ch_src1/src2/dst_addr    per-channel addresses, channel c at [c*LEN +: LEN]
//   ch_done                  per-channel completion pulse from memory
//   busy, idle               channel in-flight flags, global idle
//   done_count               completed operations (wraps)
//   err                      sticky: completion seen on an idle channel
module pim_cmd_dispatch #(
    parameter int LEN    = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN-1:0]        cmd_src1,
    input  logic [LEN-1:0]        cmd_src2,
    input  logic [LEN-1:0]        cmd_dst,
    output logic [NUM_CH-1:0]     ch_start,
    output logic [NUM_CH*LEN-1:0] ch_src1_addr,
    output logic [NUM_CH*LEN-1:0] ch_src2_addr,
    output logic [NUM_CH*LEN-1:0] ch_dst_addr,
    input  logic [NUM_CH-1:0]     ch_done,
    output logic [NUM_CH-1:0]     busy,
    output logic                  idle,
    output logic [CNT_W-1:0]      done_count,
    output logic                  err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_B = PTR_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PC_W  = $clog2(NUM_CH + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [PC_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + PC_W'(v[i]);
        end
        return sum;
    endfunction

    logic [LEN-1:0]        src1_mem_q [DEPTH];
    logic [LEN-1:0]        src2_mem_q [DEPTH];
    logic [LEN-1:0]        dst_mem_q  [DEPTH];
    logic [LEN-1:0]        src1_mem_d [DEPTH];
    logic [LEN-1:0]        src2_mem_d [DEPTH];
    logic [LEN-1:0]        dst_mem_d  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_B-1:0]      count_q, count_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]     busy_q, busy_d, start_q, start_d;
    logic [NUM_CH*LEN-1:0] ch_src1_q, ch_src1_d, ch_src2_q, ch_src2_d, ch_dst_q, ch_dst_d;
    logic [CNT_W-1:0]      done_cnt_q, done_cnt_d;
    logic                  err_q, err_d;

    logic                  fifo_empty_s, fifo_full_s, push_s, dispatch_s, hazard_s;
    logic                  sel_found_s;
    logic [CH_W-1:0]       sel_ch_s;
    logic [CH_W:0]         idx_s;
    logic [NUM_CH-1:0]     done_hit_s, done_stray_s;
    logic [LEN-1:0]        head_src1_s, head_src2_s, head_dst_s;

    assign fifo_empty_s = (count_q == '0);
    assign fifo_full_s  = (count_q == CNT_B'(DEPTH));
    // No pass-through: a full FIFO refuses input even if it pops this edge.
    assign push_s       = cmd_valid & ~fifo_full_s;
    assign head_src1_s  = src1_mem_q[rd_ptr_q];
    assign head_src2_s  = src2_mem_q[rd_ptr_q];
    assign head_dst_s   = dst_mem_q[rd_ptr_q];
    assign done_hit_s   = ch_done & busy_q;
    assign done_stray_s = ch_done & ~busy_q;

    // Round-robin search: first non-busy channel at or after rr_ptr, with wrap.
    always_comb begin
        sel_found_s = 1'b0;
        sel_ch_s    = '0;
        idx_s       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_s = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            idx_s = (idx_s >= (CH_W+1)'(NUM_CH)) ? (idx_s - (CH_W+1)'(NUM_CH)) : idx_s;
            sel_ch_s    = (!sel_found_s && !busy_q[idx_s[CH_W-1:0]]) ? idx_s[CH_W-1:0] : sel_ch_s;
            sel_found_s = sel_found_s | ~busy_q[idx_s[CH_W-1:0]];
        end
    end

`ifdef PIM_HAZARD_CHECK_EN
    // Conservative hazard check: a channel completing this edge still blocks.
    always_comb begin
        hazard_s = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            hazard_s = hazard_s | (busy_q[c] &
                       ((ch_dst_q[c*LEN +: LEN] == head_src1_s) |
                        (ch_dst_q[c*LEN +: LEN] == head_src2_s) |
                        (ch_dst_q[c*LEN +: LEN] == head_dst_s)));
        end
    end
`else
    assign hazard_s = 1'b0;
`endif

    assign dispatch_s = ~fifo_empty_s & sel_found_s & ~hazard_s;

    // Next-state: FIFO, per-channel IDLE/BUSY FSM, counters and error flag.
    always_comb begin
        src1_mem_d = src1_mem_q;
        src2_mem_d = src2_mem_q;
        dst_mem_d  = dst_mem_q;
        ch_src1_d  = ch_src1_q;
        ch_src2_d  = ch_src2_q;
        ch_dst_d   = ch_dst_q;
        busy_d     = busy_q & ~done_hit_s;
        start_d    = '0;
        if (push_s) begin
            src1_mem_d[wr_ptr_q] = cmd_src1;
            src2_mem_d[wr_ptr_q] = cmd_src2;
            dst_mem_d[wr_ptr_q]  = cmd_dst;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (dispatch_s) begin
            rd_ptr_d                     = rd_ptr_q + PTR_W'(1);
            rr_ptr_d                     = (sel_ch_s == CH_W'(NUM_CH - 1)) ? '0 : (sel_ch_s + CH_W'(1));
            busy_d[sel_ch_s]             = 1'b1;
            start_d[sel_ch_s]            = 1'b1;
            ch_src1_d[sel_ch_s*LEN +: LEN] = head_src1_s;
            ch_src2_d[sel_ch_s*LEN +: LEN] = head_src2_s;
            ch_dst_d[sel_ch_s*LEN +: LEN]  = head_dst_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
            rr_ptr_d = rr_ptr_q;
        end
        case ({push_s, dispatch_s})
            2'b10:   count_d = count_q + CNT_B'(1);
            2'b01:   count_d = count_q - CNT_B'(1);
            default: count_d = count_q;
        endcase
        done_cnt_d = done_cnt_q + CNT_W'(popcount(done_hit_s));
        err_d      = err_q | (|done_stray_s);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                src1_mem_q[i] <= '0;
                src2_mem_q[i] <= '0;
                dst_mem_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= '0;
            start_q    <= '0;
            ch_src1_q  <= '0;
            ch_src2_q  <= '0;
            ch_dst_q   <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            src1_mem_q <= src1_mem_d;
            src2_mem_q <= src2_mem_d;
            dst_mem_q  <= dst_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            ch_src1_q  <= ch_src1_d;
            ch_src2_q  <= ch_src2_d;
            ch_dst_q   <= ch_dst_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
        end
    end

    // Outputs: all derived from registered state only.
    always_comb begin
        cmd_ready    = ~fifo_full_s;
        ch_start     = start_q;
        ch_src1_addr = ch_src1_q;
        ch_src2_addr = ch_src2_q;
        ch_dst_addr  = ch_dst_q;
        busy         = busy_q;
        idle         = fifo_empty_s & ~(|busy_q);
        done_count   = done_cnt_q;
        err          = err_q;
    end

endmodule

// File: tb/tb_pim_cmd_dispatch.sv
module tb_pim_cmd_dispatch;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_src1 = 32'd0, cmd_src2 = 32'd0, cmd_dst = 32'd0;
    logic [3:0]   ch_start;
    logic [127:0] ch_src1_addr, ch_src2_addr, ch_dst_addr;
    logic [3:0]   ch_done = 4'd0;
    logic [3:0]   busy;
    logic         idle;
    logic [3:0]   done_count;
    logic         err;

    int vec_cnt = 0;
    int miss_cnt = 0;

    pim_cmd_dispatch #(.LEN(32), .NUM_CH(4), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
        .ch_start(ch_start), .ch_src1_addr(ch_src1_addr), .ch_src2_addr(ch_src2_addr),
        .ch_dst_addr(ch_dst_addr), .ch_done(ch_done), .busy(busy), .idle(idle),
        .done_count(done_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] s1, s2, d;
        logic [3:0]  done;
        logic        e_rdy;
        logic [3:0]  e_start, e_busy;
        logic        e_idle;
        logic [3:0]  e_cnt;
        logic        e_err;
        int          chk_ch;
        logic [31:0] e_s1, e_s2, e_d;
    } vec_t;

    vec_t tbl [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        ch_done = 4'd0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push_set(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_src1 = s1;
        cmd_src2 = s2;
        cmd_dst = d;
    endtask

    // Bounded wait for a start pulse; returns the channel or -1 on timeout.
    task automatic wait_start(input string nm, output int ch);
        ch = -1;
        for (int t = 0; t < 10 && ch < 0; t++) begin
            tick();
            for (int c = 0; c < 4; c++) if (ch_start[c]) ch = c;
        end
        vec_cnt++;
        if (ch < 0) begin
            miss_cnt++;
            $display("FAIL %s: got no ch_start expected a start within 10 cycles", nm);
        end
    endtask

    initial begin
        int ch;
        int last;
        // rst vld s1 s2 d done | rdy start busy idle cnt err | chk_ch s1 s2 d
        tbl[0]  = '{1'b0, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[2]  = '{1'b1, 1'b1, 32'd10,  32'd20,  32'd30,  4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 4'd0, 1'b0,  0, 32'd10,  32'd20,  32'd30};
        tbl[4]  = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'h1, 1'b0, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[5]  = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h1, 1'b1, 4'h0, 4'h0, 1'b1, 4'd1, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[6]  = '{1'b0, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[7]  = '{1'b1, 1'b1, 32'd101, 32'd201, 32'd301, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[8]  = '{1'b1, 1'b1, 32'd102, 32'd202, 32'd302, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 4'd0, 1'b0,  0, 32'd101, 32'd201, 32'd301};
        tbl[9]  = '{1'b1, 1'b1, 32'd103, 32'd203, 32'd303, 4'h0, 1'b1, 4'h2, 4'h3, 1'b0, 4'd0, 1'b0,  1, 32'd102, 32'd202, 32'd302};
        tbl[10] = '{1'b1, 1'b1, 32'd104, 32'd204, 32'd304, 4'h0, 1'b1, 4'h4, 4'h7, 1'b0, 4'd0, 1'b0,  2, 32'd103, 32'd203, 32'd303};
        tbl[11] = '{1'b1, 1'b1, 32'd105, 32'd205, 32'd305, 4'h0, 1'b1, 4'h8, 4'hF, 1'b0, 4'd0, 1'b0,  3, 32'd104, 32'd204, 32'd304};
        tbl[12] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[13] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 4'd0, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[14] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h4, 1'b1, 4'h0, 4'hB, 1'b0, 4'd1, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[15] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h4, 4'hF, 1'b0, 4'd1, 1'b0,  2, 32'd105, 32'd205, 32'd305};
        tbl[16] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 4'd1, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[17] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 4'd5, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[18] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 4'd5, 1'b0, -1, 32'd0,   32'd0,   32'd0};
        tbl[19] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h8, 1'b1, 4'h0, 4'h0, 1'b1, 4'd5, 1'b1, -1, 32'd0,   32'd0,   32'd0};
        tbl[20] = '{1'b1, 1'b0, 32'd0,   32'd0,   32'd0,   4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 4'd5, 1'b1, -1, 32'd0,   32'd0,   32'd0};

        // Table: reset, single command, round-robin, late dispatch, stray done.
        for (int r = 0; r < 21; r++) begin
            rst = tbl[r].rst;
            cmd_valid = tbl[r].vld;
            cmd_src1 = tbl[r].s1;
            cmd_src2 = tbl[r].s2;
            cmd_dst = tbl[r].d;
            ch_done = tbl[r].done;
            tick();
            chk($sformatf("row%0d.ready", r), 32'(cmd_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("row%0d.start", r), 32'(ch_start), 32'(tbl[r].e_start));
            chk($sformatf("row%0d.busy", r), 32'(busy), 32'(tbl[r].e_busy));
            chk($sformatf("row%0d.idle", r), 32'(idle), 32'(tbl[r].e_idle));
            chk($sformatf("row%0d.done_count", r), 32'(done_count), 32'(tbl[r].e_cnt));
            chk($sformatf("row%0d.err", r), 32'(err), 32'(tbl[r].e_err));
            if (tbl[r].chk_ch >= 0) begin
                chk($sformatf("row%0d.src1", r), ch_src1_addr[tbl[r].chk_ch*32 +: 32], tbl[r].e_s1);
                chk($sformatf("row%0d.src2", r), ch_src2_addr[tbl[r].chk_ch*32 +: 32], tbl[r].e_s2);
                chk($sformatf("row%0d.dst", r), ch_dst_addr[tbl[r].chk_ch*32 +: 32], tbl[r].e_d);
            end
        end
        cmd_valid = 1'b0;
        ch_done = 4'd0;

        // FIFO full with all channels busy, then in-order drain.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            push_set(32'd2000 + 32'(k), 32'd3000 + 32'(k), 32'd1000 + 32'(k));
            tick();
            if (k == 10) chk("full.ready_at7", 32'(cmd_ready), 32'd1);
        end
        chk("full.ready_at8", 32'(cmd_ready), 32'd0);
        chk("full.busy_all", 32'(busy), 32'hF);
        push_set(32'd2012, 32'd3012, 32'd1012);
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("full.held_ready", 32'(cmd_ready), 32'd0);
            chk("full.held_start", 32'(ch_start), 32'd0);
        end
        ch_done = 4'b0010;
        tick();
        ch_done = 4'd0;
        chk("full.busy_after_done", 32'(busy), 32'hD);
        chk("full.ready_no_passthru", 32'(cmd_ready), 32'd0);
        tick();
        chk("full.start_c4", 32'(ch_start), 32'h2);
        chk("full.dst_c4", ch_dst_addr[32 +: 32], 32'd1004);
        chk("full.ready_after_pop", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        last = 1;
        for (int k = 5; k <= 12; k++) begin
            ch_done = 4'(1 << last);
            tick();
            ch_done = 4'd0;
            wait_start($sformatf("full.wait_c%0d", k), ch);
            if (ch >= 0) begin
                chk($sformatf("full.order_c%0d", k), ch_dst_addr[ch*32 +: 32], 32'd1000 + 32'(k));
                last = ch;
            end
        end
        ch_done = 4'hF;
        tick();
        ch_done = 4'd0;
        chk("full.idle_end", 32'(idle), 32'd1);
        chk("full.done_count", 32'(done_count), 32'd13);

        // Address hazard between in-flight and head command.
        do_reset();
        push_set(32'd0, 32'd1, 32'd100);
        tick();
        push_set(32'd100, 32'd2, 32'd200);
        tick();
        cmd_valid = 1'b0;
        chk("haz.first_start", 32'(ch_start), 32'h1);
        tick();
`ifdef PIM_HAZARD_CHECK_EN
        chk("haz.blocked", 32'(ch_start), 32'h0);
        tick();
        chk("haz.still_blocked", 32'(ch_start), 32'h0);
        ch_done = 4'b0001;
        tick();
        ch_done = 4'd0;
        chk("haz.held_on_done_edge", 32'(ch_start), 32'h0);
        tick();
        chk("haz.released", 32'(ch_start), 32'h2);
`else
        chk("haz.no_block", 32'(ch_start), 32'h2);
`endif
        chk("haz.second_dst", ch_dst_addr[32 +: 32], 32'd200);

        // Stray completion and done_count wrap.
        do_reset();
        ch_done = 4'b1000;
        tick();
        ch_done = 4'd0;
        chk("err.set", 32'(err), 32'd1);
        chk("err.count_unchanged", 32'(done_count), 32'd0);
        tick();
        chk("err.sticky", 32'(err), 32'd1);
        for (int i = 0; i < 17; i++) begin
            push_set(32'd5000 + 32'(i), 32'd6000 + 32'(i), 32'd7000 + 32'(i));
            tick();
            cmd_valid = 1'b0;
            tick();
            chk($sformatf("wrap.start%0d", i), 32'(ch_start), 32'(1 << (i % 4)));
            ch_done = 4'(1 << (i % 4));
            tick();
            ch_done = 4'd0;
        end
        chk("wrap.done_count", 32'(done_count), 32'd1);
        chk("wrap.err_sticky", 32'(err), 32'd1);
        chk("wrap.idle", 32'(idle), 32'd1);

        // Asynchronous reset with queued and in-flight work.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            push_set(32'd8000 + 32'(k), 32'd8100 + 32'(k), 32'd8200 + 32'(k));
            tick();
        end
        cmd_valid = 1'b0;
        chk("arst.busy_before", 32'(busy), 32'hF);
        chk("arst.idle_before", 32'(idle), 32'd0);
        rst = 1'b0;
        #2;
        chk("arst.ready", 32'(cmd_ready), 32'd1);
        chk("arst.idle", 32'(idle), 32'd1);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.start", 32'(ch_start), 32'd0);
        chk("arst.dst0", ch_dst_addr[31:0], 32'd0);
        chk("arst.count", 32'(done_count), 32'd0);
        tick();
        rst = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("arst.no_start", 32'(ch_start), 32'd0);
        end
        ch_done = 4'b0001;
        tick();
        ch_done = 4'd0;
        chk("arst.late_done_err", 32'(err), 32'd1);
        chk("arst.late_done_count", 32'(done_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
